// File: rtl/bcd_tx_seq.sv
// Streams a captured multi-digit BCD value to the UART TX as ASCII, most significant
// digit first, with optional leading-zero blanking and a CR/LF trailer.
module bcd_tx_seq #(
    parameter int unsigned NDIG     = 4,
    parameter bit          CRLF     = 1'b1,
    parameter bit          LZ_BLANK = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [4*NDIG-1:0] bcd_in,
    output logic              busy,
    output logic              done,
    output logic [3:0]        asc_nib,
    input  logic [7:0]        asc_byte,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(NDIG - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StFetch,
        StSend,
        StCr,
        StLf,
        StFin
    } state_e;

    state_e            state_q, state_d;
    logic [4*NDIG-1:0] shadow_q, shadow_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              nz_q, nz_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d;
    logic              hs_q, hs_d;

    logic [4*NDIG-1:0] shifted;
    logic [3:0]        digit;
    logic              handshake;

    assign shifted   = shadow_q >> {idx_q, 2'b00};
    assign digit     = shifted[3:0];
    assign handshake = valid_q & tx_ready;

    assign asc_nib  = digit;
    assign tx_data  = data_q;
    assign tx_valid = valid_q;
    assign busy     = (state_q != StIdle) && (state_q != StFin);
    assign done     = (state_q == StFin);

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        nz_d     = nz_q;
        data_d   = data_q;
        valid_d  = valid_q;
        // One idle cycle after each handshake keeps byte spacing equal to the start latency
        hs_d     = handshake;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    shadow_d = bcd_in;
                    idx_d    = IDX_TOP;
                    nz_d     = 1'b0;
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                state_d = StFetch;
            end
            StFetch: begin
                if (!hs_q) begin
                    if (LZ_BLANK && !nz_q && (digit == 4'h0) && (idx_q != '0)) begin
                        idx_d = idx_q - 1'b1;
                    end else begin
                        data_d  = (digit == 4'h0) ? 8'h30 : asc_byte;
                        valid_d = 1'b1;
                        nz_d    = 1'b1;
                        state_d = StSend;
                    end
                end
            end
            StSend: begin
                if (handshake) begin
                    valid_d = 1'b0;
                    if (idx_q != '0) begin
                        idx_d   = idx_q - 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = CRLF ? StCr : StFin;
                    end
                end
            end
            StCr: begin
                if (!valid_q && !hs_q) begin
                    data_d  = 8'h0D;
                    valid_d = 1'b1;
                end else if (handshake) begin
                    valid_d = 1'b0;
                    state_d = StLf;
                end
            end
            StLf: begin
                if (!valid_q && !hs_q) begin
                    data_d  = 8'h0A;
                    valid_d = 1'b1;
                end else if (handshake) begin
                    valid_d = 1'b0;
                    state_d = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            shadow_q <= '0;
            idx_q    <= '0;
            nz_q     <= 1'b0;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            hs_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            nz_q     <= nz_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            hs_q     <= hs_d;
        end
    end

endmodule

// File: tb/tb_bcd_tx_seq.sv
// Directed bench for bcd_tx_seq: a blanking and a non-blanking instance share stimulus;
// a negedge monitor collects handshaken bytes and done pulses.
module tb_bcd_tx_seq;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] bcd_in;
    logic        tx_ready;

    logic        busy, done, tx_valid;
    logic [3:0]  asc_nib;
    logic [7:0]  asc_byte, tx_data;
    logic        busy_nb, done_nb, tx_valid_nb;
    logic [3:0]  asc_nib_nb;
    logic [7:0]  asc_byte_nb, tx_data_nb;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt, done_cnt_nb, done_cyc, last_hs_edge;
    bq_t q_main, q_nb, exp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] conv(input logic [3:0] n);
        if (n <= 4'd9) return 8'h30 + {4'h0, n};
        else if (n == 4'hE) return 8'h45;
        else return 8'h23;
    endfunction

    assign asc_byte    = conv(asc_nib);
    assign asc_byte_nb = conv(asc_nib_nb);

    bcd_tx_seq #(.NDIG(4), .CRLF(1'b1), .LZ_BLANK(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in), .busy(busy),
        .done(done), .asc_nib(asc_nib), .asc_byte(asc_byte), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    bcd_tx_seq #(.NDIG(4), .CRLF(1'b1), .LZ_BLANK(1'b0)) u_dut_nb (
        .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in), .busy(busy_nb),
        .done(done_nb), .asc_nib(asc_nib_nb), .asc_byte(asc_byte_nb), .tx_data(tx_data_nb),
        .tx_valid(tx_valid_nb), .tx_ready(tx_ready)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_valid && tx_ready) begin
                q_main.push_back(tx_data);
                last_hs_edge = cyc + 1;
            end
            if (tx_valid_nb && tx_ready) q_nb.push_back(tx_data_nb);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (done_nb) done_cnt_nb++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic check_frame(input string tag, input bq_t got, input bq_t want);
        check_eq({tag, "_len"}, got.size(), want.size());
        for (int i = 0; i < want.size(); i++)
            if (i < got.size()) check_eq($sformatf("%s_b%0d", tag, i), got[i], want[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        q_main.delete();
        q_nb.delete();
        done_cnt    = 0;
        done_cnt_nb = 0;
        done_cyc    = -1;
        last_hs_edge = -2;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300 && !(done_cnt > 0 && done_cnt_nb > 0); i++) tick();
        check_eq("done_seen", (done_cnt > 0 && done_cnt_nb > 0), 1);
        tick();
    endtask

    task automatic run_frame(input logic [15:0] v);
        clear();
        bcd_in = v;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        bcd_in = 16'hFFFF;
        wait_done();
    endtask

    initial begin
        // T1: reset holds everything quiet even with start asserted
        rst_n = 1'b0; start = 1'b1; bcd_in = 16'h1234; tx_ready = 1'b1;
        clear();
        for (int i = 0; i < 4; i++) tick();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_valid", tx_valid, 0);
        check_eq("rst_data", tx_data, 8'h00);
        check_eq("rst_nib", asc_nib, 4'h0);
        rst_n = 1'b1; start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check_eq("rst_quiet", q_main.size() + done_cnt, 0);

        // T2: basic frame and latencies
        clear();
        bcd_in = 16'h1234; start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("t2_busy_load", busy, 1);
        check_eq("t2_valid_n0", tx_valid, 0);
        tick();
        check_eq("t2_valid_n1", tx_valid, 0);
        tick();
        check_eq("t2_valid_n2", tx_valid, 1);
        check_eq("t2_first", tx_data, 8'h31);
        wait_done();
        exp = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};
        check_frame("t2", q_main, exp);
        check_eq("t2_done_cnt", done_cnt, 1);
        check_eq("t2_done_time", done_cyc, last_hs_edge);
        check_eq("t2_idle", busy, 0);

        // T3: leading-zero blanking on and off
        run_frame(16'h0007);
        exp = '{8'h37, 8'h0D, 8'h0A};
        check_frame("t3_lz7", q_main, exp);
        exp = '{8'h30, 8'h30, 8'h30, 8'h37, 8'h0D, 8'h0A};
        check_frame("t3_nb7", q_nb, exp);
        run_frame(16'h0000);
        exp = '{8'h30, 8'h0D, 8'h0A};
        check_frame("t3_lz0", q_main, exp);

        // T4: backpressure on byte 2
        clear();
        tx_ready = 1'b0; bcd_in = 16'h1234; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20 && !tx_valid; i++) tick();
        check_eq("t4_b1", tx_data, 8'h31);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        for (int i = 0; i < 20 && !tx_valid; i++) tick();
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("t4_hold_v%0d", i), tx_valid, 1);
            check_eq($sformatf("t4_hold_d%0d", i), tx_data, 8'h32);
            tick();
        end
        tx_ready = 1'b1;
        wait_done();
        exp = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};
        check_frame("t4", q_main, exp);

        // T5: converter mapping, starts while busy are ignored
        clear();
        bcd_in = 16'h9E0A; start = 1'b1;
        tick();
        bcd_in = 16'h5555;
        for (int i = 0; i < 8; i++) tick();
        start = 1'b0;
        wait_done();
        for (int i = 0; i < 20; i++) tick();
        exp = '{8'h39, 8'h45, 8'h30, 8'h23, 8'h0D, 8'h0A};
        check_frame("t5", q_main, exp);
        check_eq("t5_one_done", done_cnt, 1);
        check_eq("t5_idle", busy, 0);

        // T6: reset mid-frame
        clear();
        bcd_in = 16'h1234; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 50 && q_main.size() < 2; i++) tick();
        tx_ready = 1'b0;
        for (int i = 0; i < 20 && !tx_valid; i++) tick();
        check_eq("t6_b3_pending", tx_data, 8'h33);
        rst_n = 1'b0;
        #1;
        check_eq("t6_valid_drop", tx_valid, 0);
        check_eq("t6_busy_drop", busy, 0);
        for (int i = 0; i < 3; i++) tick();
        check_eq("t6_bytes", q_main.size(), 2);
        check_eq("t6_no_done", done_cnt, 0);
        rst_n = 1'b1; tx_ready = 1'b1;
        tick();
        run_frame(16'h1234);
        exp = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};
        check_frame("t6_after", q_main, exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
